alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of alu_issue_if: buffers decoded uops, reads operands from the register file, resolves RAW hazards by forwarding, and drives m_valid/m_uop/m_op1/m_op2 into the ALU stage.
- Sits between decode and the ALU stage.
- Obeys the same i_stall/i_flush contract as the ALU stage, so the two stages stay in lockstep.

Parameters:
DEPTH, 2, issue-buffer entries (power of two, >=2)
PTR_W, $clog2(DEPTH), buffer pointer width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_dec_valid  input  1  decode presents a uop
o_dec_ready  output  1  buffer can accept a uop this cycle
i_dec_uop  input  uop_t  decoded uop (uses rs1, rs2, rd, writes_rd, op1_sel, op2_sel, imm, pc, alu_op)
o_rf_rs1_addr  output  5  regfile read address 1 (head uop rs1)
o_rf_rs2_addr  output  5  regfile read address 2 (head uop rs2)
i_rf_rs1_data  input  32  async read data 1
i_rf_rs2_data  input  32  async read data 2
i_alu_fwd_rd  input  5  ALU stage destination
i_alu_fwd_result  input  32  ALU stage result (combinational)
i_alu_fwd_writes_rd  input  1  ALU stage instruction writes rd
i_wb_valid  input  1  writeback writing regfile this cycle
i_wb_rd  input  5  writeback destination
i_wb_data  input  32  writeback data
i_stall  input  1  downstream stall (same signal the ALU stage sees)
i_flush  input  1  branch/exception flush
issue_if  modport  alu_issue_if.issue  drives m_valid, m_uop, m_op1, m_op2

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: count=0, read pointer=0, write pointer=0, all entries invalid.
  - Outputs after reset: o_dec_ready=1, m_valid=0, m_uop='0, m_op1=0, m_op2=0, rf addresses=0.
- Buffer: circular FIFO with DEPTH entries. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- o_dec_ready = (count<DEPTH) && !i_flush. It depends only on registered count, not on same-cycle dequeue.
- Enqueue on clock edge when i_dec_valid && o_dec_ready.
- Dequeue on clock edge when m_valid && !i_stall.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- Issue output is combinational from the buffer head, so there is 0-cycle latency from head to interface.
  - m_valid = (count!=0) && !i_flush.
  - When m_valid=0: m_uop='0 (writes_rd=0), m_op1=0, m_op2=0. The ALU stage latches these even when invalid, so no stale rd may be forwarded back.
- Operand resolution for source rs (evaluated separately for rs1 and rs2), in priority order:
  1. rs==0 -> 0.
  2. i_alu_fwd_writes_rd && i_alu_fwd_rd==rs -> i_alu_fwd_result.
  3. i_wb_valid && i_wb_rd==rs -> i_wb_data.
  4. Otherwise -> regfile data.
- Operand selection:
  - m_op1 = op1_sel==PC ? pc : resolved rs1.
  - m_op2 = op2_sel==IMM ? imm : resolved rs2.
- Stall: buffer holds and outputs keep tracking the head. Forwarded values may change while stalled (the writeback retires); the ALU stage samples them only when !i_stall.
- Flush: on the next edge count=0 and pointers=0. A same-cycle enqueue is discarded and dequeue is suppressed. Flush overrides stall.
- Async reset mid-operation: all state clears immediately. Outputs go to reset values without waiting for an edge.
- Producer back-to-back RAW: the consumer issues the cycle after the producer, with no bubble, using the ALU forward path.

Test Plan:
- Reset then idle -> o_dec_ready=1, m_valid=0, m_uop='0, m_op1=m_op2=0.
- ADDI x1,x0,5 then ADD x2,x1,x1, stall=0 -> cycle 2 issues ADD with m_op1=m_op2=5 via ALU forward. No bubble.
- x3: ALU forward with rd=3 (result 7) and writeback valid with rd=3 (data 9) at the same time; uop rs1=x3 -> m_op1=7 (ALU wins). Same case with rs1=x0 -> m_op1=0.
- Enqueue 3 uops with i_stall=1 and DEPTH=2 -> o_dec_ready=0 after 2 accepts, 3rd held by decode. Release stall -> issue in order, ready rises the cycle count drops.
- Buffer holds 2 uops and i_flush=1 in the same cycle as i_dec_valid=1 -> m_valid=0 that cycle, count=0 next cycle, flushed uops never issue.
- Assert rst_n=0 mid-stream between edges -> m_valid falls immediately. After release the first enqueued uop issues cleanly.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage: buffers decoded uops, resolves operands (ALU forward > writeback > regfile)
// and presents the buffer head combinationally to the ALU stage over alu_issue_if.

package alu_issue_pkg;
    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        op1_sel;
        logic        op2_sel;
        logic        writes_rd;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
    } uop_t;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;
endpackage

interface alu_issue_if;
    import alu_issue_pkg::*;
    logic        m_valid;
    uop_t        m_uop;
    logic [31:0] m_op1;
    logic [31:0] m_op2;

    modport issue (output m_valid, output m_uop, output m_op1, output m_op2);
    modport alu   (input  m_valid, input  m_uop, input  m_op1, input  m_op2);
endinterface

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_dec_valid,
    output logic        o_dec_ready,
    input  uop_t        i_dec_uop,
    output logic [4:0]  o_rf_rs1_addr,
    output logic [4:0]  o_rf_rs2_addr,
    input  logic [31:0] i_rf_rs1_data,
    input  logic [31:0] i_rf_rs2_data,
    input  logic [4:0]  i_alu_fwd_rd,
    input  logic [31:0] i_alu_fwd_result,
    input  logic        i_alu_fwd_writes_rd,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_stall,
    input  logic        i_flush,
    alu_issue_if.issue  issue_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ZERO = PTR_W'(1'b0);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   C_CNT_ZERO = (PTR_W+1)'(1'b0);
    localparam logic [PTR_W:0]   C_CNT_ONE  = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   C_DEPTH    = (PTR_W+1)'(DEPTH);

    // Source priority: x0, then the instruction in the ALU stage, then writeback, then regfile.
    function automatic logic [31:0] f_resolve(
        input logic [4:0]  rs,
        input logic        alu_wr,
        input logic [4:0]  alu_rd,
        input logic [31:0] alu_res,
        input logic        wb_v,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_data,
        input logic [31:0] rf_data
    );
        logic [31:0] res;
        if (rs == 5'd0) begin
            res = 32'd0;
        end else if (alu_wr && (alu_rd == rs)) begin
            res = alu_res;
        end else if (wb_v && (wb_rd == rs)) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    uop_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic        w_nonempty;
    logic        w_valid;
    logic        w_enq;
    logic        w_deq;
    uop_t        w_head;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_nonempty  = (r_count != C_CNT_ZERO);
    assign w_valid     = w_nonempty && !i_flush;
    assign o_dec_ready = (r_count < C_DEPTH) && !i_flush;
    assign w_enq       = i_dec_valid && o_dec_ready;
    assign w_deq       = w_valid && !i_stall;
    assign w_head      = r_mem[r_rd_ptr];

    assign w_rs1_val = f_resolve(w_head.rs1, i_alu_fwd_writes_rd, i_alu_fwd_rd, i_alu_fwd_result,
                                 i_wb_valid, i_wb_rd, i_wb_data, i_rf_rs1_data);
    assign w_rs2_val = f_resolve(w_head.rs2, i_alu_fwd_writes_rd, i_alu_fwd_rd, i_alu_fwd_result,
                                 i_wb_valid, i_wb_rd, i_wb_data, i_rf_rs2_data);

    assign o_rf_rs1_addr = w_nonempty ? w_head.rs1 : 5'd0;
    assign o_rf_rs2_addr = w_nonempty ? w_head.rs2 : 5'd0;

    // Pointer and occupancy state; flush empties the buffer and overrides stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= C_PTR_ZERO;
            r_wr_ptr <= C_PTR_ZERO;
            r_count  <= C_CNT_ZERO;
        end else if (i_flush) begin
            r_rd_ptr <= C_PTR_ZERO;
            r_wr_ptr <= C_PTR_ZERO;
            r_count  <= C_CNT_ZERO;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; occupancy alone decides validity, so the payload needs no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= i_dec_uop;
        end
    end

    // Invalid cycles drive an all-zero uop so the ALU stage never forwards a stale rd.
    always_comb begin
        issue_if.m_valid = w_valid;
        issue_if.m_uop   = '0;
        issue_if.m_op1   = 32'd0;
        issue_if.m_op2   = 32'd0;
        if (w_valid) begin
            issue_if.m_uop = w_head;
            issue_if.m_op1 = (w_head.op1_sel == OP1_PC)  ? w_head.pc  : w_rs1_val;
            issue_if.m_op2 = (w_head.op2_sel == OP2_IMM) ? w_head.imm : w_rs2_val;
        end else begin
            issue_if.m_uop = '0;
            issue_if.m_op1 = 32'd0;
            issue_if.m_op2 = 32'd0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: scoreboard of expected issues plus
// per-scenario inline checks of handshake, forwarding and flush/reset behaviour.

module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    typedef struct {
        uop_t        uop;
        logic [31:0] op1;
        logic [31:0] op2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_dec_valid;
    logic        o_dec_ready;
    uop_t        i_dec_uop;
    logic [4:0]  o_rf_rs1_addr;
    logic [4:0]  o_rf_rs2_addr;
    logic [31:0] i_rf_rs1_data;
    logic [31:0] i_rf_rs2_data;
    logic [4:0]  i_alu_fwd_rd;
    logic [31:0] i_alu_fwd_result;
    logic        i_alu_fwd_writes_rd;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        i_stall;
    logic        i_flush;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    alu_issue_if ifc();

    alu_issue_stage #(.DEPTH(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_dec_valid         (i_dec_valid),
        .o_dec_ready         (o_dec_ready),
        .i_dec_uop           (i_dec_uop),
        .o_rf_rs1_addr       (o_rf_rs1_addr),
        .o_rf_rs2_addr       (o_rf_rs2_addr),
        .i_rf_rs1_data       (i_rf_rs1_data),
        .i_rf_rs2_data       (i_rf_rs2_data),
        .i_alu_fwd_rd        (i_alu_fwd_rd),
        .i_alu_fwd_result    (i_alu_fwd_result),
        .i_alu_fwd_writes_rd (i_alu_fwd_writes_rd),
        .i_wb_valid          (i_wb_valid),
        .i_wb_rd             (i_wb_rd),
        .i_wb_data           (i_wb_data),
        .i_stall             (i_stall),
        .i_flush             (i_flush),
        .issue_if            (ifc)
    );

    always #5 clk = ~clk;

    function automatic uop_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wr, input logic s1, input logic s2,
                                input logic [31:0] imm, input logic [31:0] pc);
        uop_t u;
        u = '0;
        u.rs1 = rs1; u.rs2 = rs2; u.rd = rd; u.writes_rd = wr;
        u.op1_sel = s1; u.op2_sel = s2; u.imm = imm; u.pc = pc;
        u.alu_op = 4'd0;
        return u;
    endfunction

    // Scoreboard monitor: every accepted issue must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && ifc.m_valid && !i_stall) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got uop=%h op1=%h op2=%h, expected no issue",
                         ifc.m_uop, ifc.m_op1, ifc.m_op2);
            end else begin
                mon_e = sb.pop_front();
                if (ifc.m_uop !== mon_e.uop || ifc.m_op1 !== mon_e.op1 || ifc.m_op2 !== mon_e.op2) begin
                    errors++;
                    $display("FAIL issue_data: got uop=%h op1=%h op2=%h, expected uop=%h op1=%h op2=%h",
                             ifc.m_uop, ifc.m_op1, ifc.m_op2, mon_e.uop, mon_e.op1, mon_e.op2);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_dec_valid = 1'b0; i_dec_uop = '0;
        i_rf_rs1_data = 32'd0; i_rf_rs2_data = 32'd0;
        i_alu_fwd_rd = 5'd0; i_alu_fwd_result = 32'd0; i_alu_fwd_writes_rd = 1'b0;
        i_wb_valid = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'd0;
        i_stall = 1'b0; i_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_dec_ready); end
        checks++; if (ifc.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifc.m_valid); end
        checks++; if (ifc.m_uop !== '0) begin errors++; $display("FAIL reset_uop: got %h expected 0", ifc.m_uop); end
        checks++; if (ifc.m_op1 !== 32'd0) begin errors++; $display("FAIL reset_op1: got %h expected 0", ifc.m_op1); end
        checks++; if (ifc.m_op2 !== 32'd0) begin errors++; $display("FAIL reset_op2: got %h expected 0", ifc.m_op2); end
        checks++; if (o_rf_rs1_addr !== 5'd0 || o_rf_rs2_addr !== 5'd0) begin
            errors++; $display("FAIL reset_rf_addr: got %0d/%0d expected 0/0", o_rf_rs1_addr, o_rf_rs2_addr);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        #2;
        checks++; if (ifc.m_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", ifc.m_valid); end
    endtask

    task automatic test_back_to_back();
        uop_t addi;
        uop_t add;
        addi = mk(5'd0, 5'd0, 5'd1, 1'b1, OP1_RS1, OP2_IMM, 32'd5, 32'h40);
        add  = mk(5'd1, 5'd1, 5'd2, 1'b1, OP1_RS1, OP2_RS2, 32'd0, 32'h44);
        step();
        i_rf_rs1_data = 32'hDEAD_BEEF; i_rf_rs2_data = 32'hDEAD_BEEF;
        i_dec_valid = 1'b1; i_dec_uop = addi;
        sb.push_back('{addi, 32'd0, 32'd5});
        step();
        i_dec_uop = add;
        sb.push_back('{add, 32'd5, 32'd5});
        #2;
        checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", o_dec_ready); end
        step();
        i_dec_valid = 1'b0;
        i_alu_fwd_rd = 5'd1; i_alu_fwd_result = 32'd5; i_alu_fwd_writes_rd = 1'b1;
        #2;
        checks++; if (ifc.m_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got m_valid=%b expected 1", ifc.m_valid); end
        step();
        i_alu_fwd_writes_rd = 1'b0;
        #2;
        checks++; if (ifc.m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got m_valid=%b expected 0", ifc.m_valid); end
    endtask

    task automatic test_fwd_priority();
        uop_t u3;
        uop_t u0;
        u3 = mk(5'd3, 5'd5, 5'd6, 1'b1, OP1_RS1, OP2_RS2, 32'd0, 32'h80);
        u0 = mk(5'd0, 5'd0, 5'd7, 1'b1, OP1_RS1, OP2_RS2, 32'd0, 32'h84);
        step();
        i_stall = 1'b1; i_dec_valid = 1'b1; i_dec_uop = u3;
        i_rf_rs1_data = 32'h11; i_rf_rs2_data = 32'h22;
        step();
        i_dec_valid = 1'b0;
        i_alu_fwd_rd = 5'd3; i_alu_fwd_result = 32'd7; i_alu_fwd_writes_rd = 1'b1;
        i_wb_valid = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'd9;
        #2;
        checks++; if (ifc.m_op1 !== 32'd7) begin errors++; $display("FAIL fwd_alu_wins: got %h expected 7", ifc.m_op1); end
        checks++; if (ifc.m_op2 !== 32'h22) begin errors++; $display("FAIL fwd_rf_rs2: got %h expected 22", ifc.m_op2); end
        checks++; if (o_rf_rs1_addr !== 5'd3 || o_rf_rs2_addr !== 5'd5) begin
            errors++; $display("FAIL rf_addr: got %0d/%0d expected 3/5", o_rf_rs1_addr, o_rf_rs2_addr);
        end
        step();
        i_alu_fwd_writes_rd = 1'b0;
        #2;
        checks++; if (ifc.m_op1 !== 32'd9) begin errors++; $display("FAIL fwd_wb: got %h expected 9", ifc.m_op1); end
        step();
        i_wb_valid = 1'b0;
        #2;
        checks++; if (ifc.m_op1 !== 32'h11) begin errors++; $display("FAIL fwd_rf: got %h expected 11", ifc.m_op1); end
        step();
        i_alu_fwd_writes_rd = 1'b1; i_wb_valid = 1'b1; i_stall = 1'b0;
        sb.push_back('{u3, 32'd7, 32'h22});
        step();
        i_alu_fwd_rd = 5'd0; i_wb_rd = 5'd0;
        i_dec_valid = 1'b1; i_dec_uop = u0;
        sb.push_back('{u0, 32'd0, 32'd0});
        step();
        i_dec_valid = 1'b0;
        #2;
        checks++; if (ifc.m_op1 !== 32'd0) begin errors++; $display("FAIL fwd_x0: got %h expected 0", ifc.m_op1); end
        step();
        i_alu_fwd_writes_rd = 1'b0; i_wb_valid = 1'b0;
    endtask

    task automatic test_full_stall();
        uop_t u[3];
        for (int k = 0; k < 3; k++) begin
            u[k] = mk(5'd0, 5'd0, 5'd8, 1'b1, OP1_PC, OP2_IMM, 32'h10 + 32'(k), 32'h1000 + 32'(k * 4));
        end
        step();
        i_stall = 1'b1; i_dec_valid = 1'b1; i_dec_uop = u[0];
        sb.push_back('{u[0], u[0].pc, u[0].imm});
        #2;
        checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL full_ready0: got %b expected 1", o_dec_ready); end
        step();
        i_dec_uop = u[1];
        sb.push_back('{u[1], u[1].pc, u[1].imm});
        #2;
        checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %b expected 1", o_dec_ready); end
        step();
        i_dec_uop = u[2];
        #2;
        checks++; if (o_dec_ready !== 1'b0) begin errors++; $display("FAIL full_ready_full: got %b expected 0", o_dec_ready); end
        step();
        i_stall = 1'b0;
        #2;
        checks++; if (o_dec_ready !== 1'b0) begin errors++; $display("FAIL full_ready_deq: got %b expected 0", o_dec_ready); end
        step();
        sb.push_back('{u[2], u[2].pc, u[2].imm});
        #2;
        checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %b expected 1", o_dec_ready); end
        step();
        i_dec_valid = 1'b0;
        #2;
        checks++; if (ifc.m_valid !== 1'b1) begin errors++; $display("FAIL full_last_valid: got %b expected 1", ifc.m_valid); end
        step();
        #2;
        checks++; if (ifc.m_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", ifc.m_valid); end
    endtask

    task automatic test_flush();
        step();
        i_stall = 1'b1; i_dec_valid = 1'b1;
        i_dec_uop = mk(5'd0, 5'd0, 5'd9, 1'b1, OP1_PC, OP2_IMM, 32'hA1, 32'h2000);
        step();
        i_dec_uop = mk(5'd0, 5'd0, 5'd10, 1'b1, OP1_PC, OP2_IMM, 32'hA2, 32'h2004);
        step();
        i_flush = 1'b1;
        i_dec_uop = mk(5'd0, 5'd0, 5'd11, 1'b1, OP1_PC, OP2_IMM, 32'hA3, 32'h2008);
        #2;
        checks++; if (ifc.m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ifc.m_valid); end
        checks++; if (ifc.m_uop !== '0 || ifc.m_op1 !== 32'd0) begin
            errors++; $display("FAIL flush_payload: got uop=%h op1=%h expected 0", ifc.m_uop, ifc.m_op1);
        end
        checks++; if (o_dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", o_dec_ready); end
        step();
        i_flush = 1'b0; i_stall = 1'b0; i_dec_valid = 1'b0;
        #2;
        checks++; if (ifc.m_valid !== 1'b0 || o_dec_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty: got valid=%b ready=%b expected 0/1", ifc.m_valid, o_dec_ready);
        end
        step(); step();
    endtask

    task automatic test_async_reset();
        uop_t ur;
        uop_t us;
        ur = mk(5'd0, 5'd0, 5'd12, 1'b1, OP1_PC, OP2_IMM, 32'hB1, 32'h3000);
        us = mk(5'd0, 5'd0, 5'd13, 1'b1, OP1_PC, OP2_IMM, 32'hB2, 32'h3004);
        step();
        i_stall = 1'b1; i_dec_valid = 1'b1; i_dec_uop = ur;
        step();
        i_dec_valid = 1'b0;
        #2;
        checks++; if (ifc.m_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", ifc.m_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ifc.m_valid !== 1'b0 || ifc.m_op1 !== 32'd0) begin
            errors++; $display("FAIL arst_immediate: got valid=%b op1=%h expected 0/0", ifc.m_valid, ifc.m_op1);
        end
        checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", o_dec_ready); end
        step();
        rst_n = 1'b1; i_stall = 1'b0;
        i_dec_valid = 1'b1; i_dec_uop = us;
        sb.push_back('{us, us.pc, us.imm});
        step();
        i_dec_valid = 1'b0;
        #2;
        checks++; if (ifc.m_op1 !== 32'h3004) begin errors++; $display("FAIL arst_first_issue: got %h expected 3004", ifc.m_op1); end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fwd_priority();
        test_full_stall();
        test_flush();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
